clk_phase_sequencer: RTL and testbench

- Generates the CPU timebase from the 50 MHz board oscillator on ext_clk.
- A free-running prescaler produces a 10 MHz single-cycle enable strobe and a 10 MHz square wave.
- A run/step/halt state machine sequences one-hot machine-cycle phases T1..Tn on those strobes, so downstream logic runs in the ext_clk domain using enables, not derived clocks.
- Sits directly under the toplevel, between the oscillator input and the processor datapath.

---
 rtl/d3_timing_pkg.sv | 20 ++
 rtl/clk_prescaler.sv | 40 ++++
 rtl/clk_phase_sequencer.sv | 120 ++++++++++++
 tb/tb_clk_phase_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/d3_timing_pkg.sv
// ============================================================================
// d3_timing_pkg : shared timebase types and default constants
// Rev 1.0
// ============================================================================
`default_nettype none

package d3_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } seq_state_t;

  localparam int DIV_10MHZ = 5;
  localparam int MC_PHASES = 4;

endpackage

`default_nettype wire

// File: rtl/clk_prescaler.sv
// ============================================================================
// clk_prescaler : free-running divide-by-DIV enable strobe and square wave
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_prescaler #(
  parameter int DIV = 5,
  parameter int CW  = $clog2(DIV)
) (
  input  logic clk,
  input  logic rst,
  output logic tick_cond,
  output logic tick,
  output logic mhz
);

  localparam int HIGH_CNT = (DIV + 1) / 2;

  logic [CW-1:0] cnt;

  // Combinational terminal count: the sequencer advances on this edge,
  // which is the same edge that raises the registered tick.
  assign tick_cond = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
      mhz  <= 1'b0;
    end else begin
      cnt  <= tick_cond ? '0 : cnt + 1'b1;
      tick <= tick_cond;
      mhz  <= (cnt < CW'(HIGH_CNT));
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_phase_sequencer.sv
// ============================================================================
// clk_phase_sequencer : 10 MHz enable timebase and run/step/halt T-phase FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_phase_sequencer
  import d3_timing_pkg::*;
#(
  parameter int DIV        = DIV_10MHZ,
  parameter int NUM_PHASES = MC_PHASES,
  parameter int CW         = $clog2(DIV)
) (
  input  logic                  ext_clk,
  input  logic                  ext_reset,
  input  logic                  run_req,
  input  logic                  step_req,
  output logic                  tick_10,
  output logic                  mhz_10,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  cycle_start,
  output logic                  cycle_done,
  output logic                  halted
);

  localparam logic [NUM_PHASES-1:0] T1 = NUM_PHASES'(1);

  logic tick_cond;

  clk_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk       (ext_clk),
    .rst       (ext_reset),
    .tick_cond (tick_cond),
    .tick      (tick_10),
    .mhz       (mhz_10)
  );

  seq_state_t            state, state_n;
  logic [NUM_PHASES-1:0] phase_n;
  logic                  step_pending, step_pending_n;
  logic                  cycle_start_n, cycle_done_n;
  logic                  step_seen;

  always_ff @(posedge ext_clk) begin
    if (ext_reset) begin
      state        <= IDLE;
      phase        <= '0;
      step_pending <= 1'b0;
      cycle_start  <= 1'b0;
      cycle_done   <= 1'b0;
      halted       <= 1'b1;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      step_pending <= step_pending_n;
      cycle_start  <= cycle_start_n;
      cycle_done   <= cycle_done_n;
      halted       <= (state_n == IDLE);
    end
  end

  always_comb begin
    state_n        = state;
    phase_n        = phase;
    step_pending_n = step_pending;
    cycle_start_n  = 1'b0;
    cycle_done_n   = 1'b0;
    // A step request landing on the tick cycle itself still counts.
    step_seen      = step_pending | step_req;

    unique case (state)
      IDLE: begin
        phase_n        = '0;
        step_pending_n = step_seen;
        if (tick_cond) begin
          step_pending_n = 1'b0;
          if (run_req) begin
            state_n       = RUN;
            phase_n       = T1;
            cycle_start_n = 1'b1;
          end else if (step_seen) begin
            state_n       = STEP;
            phase_n       = T1;
            cycle_start_n = 1'b1;
          end
        end
      end

      RUN, STEP: begin
        step_pending_n = 1'b0;
        if (tick_cond) begin
          if (phase[NUM_PHASES-1]) begin
            cycle_done_n = 1'b1;
            if (run_req) begin
              state_n       = RUN;
              phase_n       = T1;
              cycle_start_n = 1'b1;
            end else begin
              state_n = IDLE;
              phase_n = '0;
            end
          end else begin
            phase_n = {phase[NUM_PHASES-2:0], 1'b0};
          end
        end
      end

      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_phase_sequencer.sv
// ============================================================================
// tb_clk_phase_sequencer : directed vector bench for clk_phase_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_phase_sequencer;

  logic       ext_clk = 1'b0;
  logic       ext_reset;
  logic       run_req;
  logic       step_req;
  logic       tick_10;
  logic       mhz_10;
  logic [3:0] phase;
  logic       cycle_start;
  logic       cycle_done;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 ext_clk = ~ext_clk;

  clk_phase_sequencer #(
    .DIV        (5),
    .NUM_PHASES (4)
  ) dut (
    .ext_clk     (ext_clk),
    .ext_reset   (ext_reset),
    .run_req     (run_req),
    .step_req    (step_req),
    .tick_10     (tick_10),
    .mhz_10      (mhz_10),
    .phase       (phase),
    .cycle_start (cycle_start),
    .cycle_done  (cycle_done),
    .halted      (halted)
  );

  typedef struct {
    int         cycles;
    logic       run;
    logic       step;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[18];

  // Observation word: {tick_10, mhz_10, phase[3:0], cycle_start, cycle_done, halted}
  function automatic logic [8:0] ex(bit t, bit m, logic [3:0] p, bit s, bit d, bit h);
    return {t, m, p, s, d, h};
  endfunction

  function automatic logic [8:0] obs();
    return {tick_10, mhz_10, phase, cycle_start, cycle_done, halted};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (tick mhz phase start done halted)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int         starts[$];
  int         dones[$];
  int         onehot_bad;
  logic [3:0] ph_a, ph_b;
  logic       h_a, h_b;
  logic [8:0] v_rst;
  logic       t21, t22, m18;

  initial begin
    // Idle prescale, then a single step cycle: T1 at k=15 .. IDLE at k=35.
    vecs[0]  = '{1,  1'b0, 1'b0, ex(0, 1, 4'h0, 0, 0, 1)};
    vecs[1]  = '{2,  1'b0, 1'b0, ex(0, 1, 4'h0, 0, 0, 1)};
    vecs[2]  = '{1,  1'b0, 1'b0, ex(0, 0, 4'h0, 0, 0, 1)};
    vecs[3]  = '{1,  1'b0, 1'b0, ex(1, 0, 4'h0, 0, 0, 1)};
    vecs[4]  = '{1,  1'b0, 1'b0, ex(0, 1, 4'h0, 0, 0, 1)};
    vecs[5]  = '{4,  1'b0, 1'b0, ex(1, 0, 4'h0, 0, 0, 1)};
    vecs[6]  = '{1,  1'b0, 1'b0, ex(0, 1, 4'h0, 0, 0, 1)};
    vecs[7]  = '{1,  1'b0, 1'b1, ex(0, 1, 4'h0, 0, 0, 1)};
    vecs[8]  = '{2,  1'b0, 1'b0, ex(0, 0, 4'h0, 0, 0, 1)};
    vecs[9]  = '{1,  1'b0, 1'b0, ex(1, 0, 4'h1, 1, 0, 0)};
    vecs[10] = '{1,  1'b0, 1'b0, ex(0, 1, 4'h1, 0, 0, 0)};
    vecs[11] = '{4,  1'b0, 1'b0, ex(1, 0, 4'h2, 0, 0, 0)};
    vecs[12] = '{5,  1'b0, 1'b0, ex(1, 0, 4'h4, 0, 0, 0)};
    vecs[13] = '{5,  1'b0, 1'b0, ex(1, 0, 4'h8, 0, 0, 0)};
    vecs[14] = '{4,  1'b0, 1'b0, ex(0, 0, 4'h8, 0, 0, 0)};
    vecs[15] = '{1,  1'b0, 1'b0, ex(1, 0, 4'h0, 0, 1, 1)};
    vecs[16] = '{1,  1'b0, 1'b0, ex(0, 1, 4'h0, 0, 0, 1)};
    vecs[17] = '{14, 1'b0, 1'b0, ex(1, 0, 4'h0, 0, 0, 1)};

    ext_reset = 1'b1;
    run_req   = 1'b0;
    step_req  = 1'b0;
    repeat (3) @(negedge ext_clk);
    check("reset_state", obs(), ex(0, 0, 4'h0, 0, 0, 1));
    ext_reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_req  = vecs[i].run;
      step_req = vecs[i].step;
      repeat (vecs[i].cycles) @(negedge ext_clk);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    step_req = 1'b0;

    // Continuous run for three cycles; run drops during T2 of cycle 3, steps ignored.
    starts.delete(); dones.delete(); onehot_bad = 0;
    for (int r = 1; r <= 90; r++) begin
      run_req  = (r <= 51);
      step_req = (r == 12 || r == 32);
      @(negedge ext_clk);
      if (cycle_start) starts.push_back(r);
      if (cycle_done)  dones.push_back(r);
      if ($countones(phase) > 1) onehot_bad++;
      if (r == 60) ph_a = phase;
      if (r == 65) begin ph_b = phase; h_a = halted; end
      if (r == 90) h_b = halted;
    end
    check_int("run_start_count", starts.size(), 3);
    check_int("run_start0", starts.size() > 0 ? starts[0] : -1, 5);
    check_int("run_start1", starts.size() > 1 ? starts[1] : -1, 25);
    check_int("run_start2", starts.size() > 2 ? starts[2] : -1, 45);
    check_int("run_done_count", dones.size(), 3);
    check_int("run_done0", dones.size() > 0 ? dones[0] : -1, 25);
    check_int("run_done1", dones.size() > 1 ? dones[1] : -1, 45);
    check_int("run_done2", dones.size() > 2 ? dones[2] : -1, 65);
    check_int("run_t4_phase", int'(ph_a), 8);
    check_int("run_halt_phase", int'(ph_b), 0);
    check_int("run_halted_at_done", int'(h_a), 1);
    check_int("run_halted_late", int'(h_b), 1);
    check_int("run_onehot", onehot_bad, 0);

    // Simultaneous run and step in IDLE: run wins, no trailing step cycle.
    starts.delete(); dones.delete();
    for (int r = 1; r <= 60; r++) begin
      run_req  = (r <= 6);
      step_req = (r == 1);
      @(negedge ext_clk);
      if (cycle_start) starts.push_back(r);
      if (cycle_done)  dones.push_back(r);
      if (r == 60) begin ph_a = phase; h_a = halted; end
    end
    check_int("both_start_count", starts.size(), 1);
    check_int("both_start0", starts.size() > 0 ? starts[0] : -1, 5);
    check_int("both_done_count", dones.size(), 1);
    check_int("both_done0", dones.size() > 0 ? dones[0] : -1, 25);
    check("both_final", {4'h0, ph_a, h_a}, {4'h0, 4'h0, 1'b1});

    // Reset during T3 of a step cycle.
    starts.delete(); dones.delete();
    for (int r = 1; r <= 30; r++) begin
      run_req   = 1'b0;
      step_req  = (r == 2);
      ext_reset = (r == 17);
      @(negedge ext_clk);
      if (cycle_start) starts.push_back(r);
      if (cycle_done)  dones.push_back(r);
      if (r == 15) ph_a = phase;
      if (r == 17) v_rst = obs();
      if (r == 18) m18 = mhz_10;
      if (r == 21) t21 = tick_10;
      if (r == 22) t22 = tick_10;
    end
    ext_reset = 1'b0;
    check_int("rst_pre_t3", int'(ph_a), 4);
    check("rst_state", v_rst, ex(0, 0, 4'h0, 0, 0, 1));
    check_int("rst_no_done", dones.size(), 0);
    check_int("rst_start_count", starts.size(), 1);
    check_int("rst_mhz_first", int'(m18), 1);
    check_int("rst_tick_early", int'(t21), 0);
    check_int("rst_tick_first", int'(t22), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
